// File: rtl/mor1kx_true_dpram_be_sclk_pkg.sv
// Shared definitions for the byte-enable true dual-port RAM: read-during-write
// mode encodings, clear sequencer states and the per-byte merge helper.
package mor1kx_true_dpram_be_sclk_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;
  localparam int RDW_NO_CHANGE   = 2;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  // Final value of one byte lane: own write wins, then the other port's
  // surviving write to the same word, otherwise the stored byte.
  function automatic logic [7:0] lane_sel(input logic       own_we,
                                          input logic [7:0] own,
                                          input logic       oth_we,
                                          input logic [7:0] oth,
                                          input logic [7:0] old);
    return own_we ? own : (oth_we ? oth : old);
  endfunction

endpackage

// File: rtl/mor1kx_dpram_out_pipe.sv
// Per-port read result register with an optional second stage; the valid
// strobe travels alongside the data in a shift register.
module mor1kx_dpram_out_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  rvalid_o
);

  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  logic [STAGES:1]       vld_pipe;
  logic [DATA_WIDTH-1:0] s1_q;

  // Stage 1 only loads on an access so dout holds across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | STAGES'(ld_i);
      if (ld_i)
        s1_q <= data_i;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] s2_q;
      always_ff @(posedge clk) begin
        if (rst) s2_q <= '0;
        else     s2_q <= s1_q;
      end
      assign dout_o = s2_q;
    end else begin : g_noreg
      assign dout_o = s1_q;
    end
  endgenerate

  assign rvalid_o = vld_pipe[STAGES];

endmodule

// File: rtl/mor1kx_true_dpram_be_sclk.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-
// write behaviour, collision resolution and an optional zero-fill sequencer.
module mor1kx_true_dpram_be_sclk
  import mor1kx_true_dpram_be_sclk_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int RDW_MODE       = RDW_WRITE_FIRST,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a_i,
  input  logic [BE_WIDTH-1:0]   we_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [DATA_WIDTH-1:0] din_a_i,
  output logic [DATA_WIDTH-1:0] dout_a_o,
  output logic                  rvalid_a_o,
  input  logic                  en_b_i,
  input  logic [BE_WIDTH-1:0]   we_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [DATA_WIDTH-1:0] din_b_i,
  output logic [DATA_WIDTH-1:0] dout_b_o,
  output logic                  rvalid_b_o,
  output logic                  collision_o,
  output logic                  busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_we;
  logic                  busy;

  logic                  acc_a, acc_b, wr_a, wr_b, coll, coll_q;
  logic [BE_WIDTH-1:0]   ben_a, ben_b;
  logic [DATA_WIDTH-1:0] old_a, old_b, mrg_a, mrg_b, rd_a, rd_b;
  logic                  ld_a, ld_b;

  // ---------------------------------------------------------------- clear FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLR_CLEAR : CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLR_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = CLR_IDLE;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign busy   = (state_q == CLR_CLEAR);
  assign busy_o = busy;

  // ------------------------------------------------------------- port access
  // rst gates accesses too, so the array is never touched on a reset edge.
  assign acc_a = en_a_i & ~busy & ~rst;
  assign acc_b = en_b_i & ~busy & ~rst;
  assign wr_a  = acc_a & (|we_a_i);
  assign wr_b  = acc_b & (|we_b_i);
  assign coll  = wr_a & wr_b & (addr_a_i == addr_b_i);

  // On a collision B drops only the bytes A also writes.
  assign ben_a = {BE_WIDTH{wr_a}} & we_a_i;
  assign ben_b = {BE_WIDTH{wr_b}} & we_b_i & ~({BE_WIDTH{coll}} & ben_a);

  assign old_a = mem[addr_a_i];
  assign old_b = mem[addr_b_i];

  genvar g;
  generate
    for (g = 0; g < BE_WIDTH; g++) begin : g_lane
      assign mrg_a[g*8 +: 8] = lane_sel(ben_a[g], din_a_i[g*8 +: 8],
                                        coll & ben_b[g], din_b_i[g*8 +: 8],
                                        old_a[g*8 +: 8]);
      assign mrg_b[g*8 +: 8] = lane_sel(ben_b[g], din_b_i[g*8 +: 8],
                                        coll & ben_a[g], din_a_i[g*8 +: 8],
                                        old_b[g*8 +: 8]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (ben_a[i]) mem[addr_a_i][i*8 +: 8] <= din_a_i[i*8 +: 8];
        if (ben_b[i]) mem[addr_b_i][i*8 +: 8] <= din_b_i[i*8 +: 8];
      end
    end
  end

  // ------------------------------------------------------ read-during-write
  // A read of a word the other port writes this cycle sees old_x, because
  // only a same-port write selects the merged word.
  assign rd_a = (wr_a && RDW_MODE == RDW_WRITE_FIRST) ? mrg_a : old_a;
  assign rd_b = (wr_b && RDW_MODE == RDW_WRITE_FIRST) ? mrg_b : old_b;
  assign ld_a = acc_a & ~(wr_a & (RDW_MODE == RDW_NO_CHANGE));
  assign ld_b = acc_b & ~(wr_b & (RDW_MODE == RDW_NO_CHANGE));

  always_ff @(posedge clk) begin
    if (rst) coll_q <= 1'b0;
    else     coll_q <= coll;
  end
  assign collision_o = coll_q;

  mor1kx_dpram_out_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_pipe_a (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (ld_a),
    .data_i   (rd_a),
    .dout_o   (dout_a_o),
    .rvalid_o (rvalid_a_o)
  );

  mor1kx_dpram_out_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_pipe_b (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (ld_b),
    .data_i   (rd_b),
    .dout_o   (dout_b_o),
    .rvalid_o (rvalid_b_o)
  );

endmodule

// File: tb/tb_mor1kx_true_dpram_be_sclk.sv
// Directed bench: four RAM instances (WRITE_FIRST, READ_FIRST, NO_CHANGE,
// WRITE_FIRST+OUT_REG) share stimulus and are checked against fixed vectors.
module tb_mor1kx_true_dpram_be_sclk;

  localparam int WF = 0, RF = 1, NC = 2, ORG = 3;
  localparam logic [3:0][1:0] RDW  = {2'd0, 2'd2, 2'd1, 2'd0};
  localparam logic [3:0]      OREG = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b, addr_a, addr_b;
  logic [31:0] din_a, din_b;
  logic [31:0] dout_a [4];
  logic [31:0] dout_b [4];
  logic        rvalid_a [4];
  logic        rvalid_b [4];
  logic        collision [4];
  logic        busy [4];

  int   checks = 0;
  int   errors = 0;
  int   n;
  logic rv_seen;
  logic [31:0] exp_or [5] = '{32'h0, 32'h101, 32'h202, 32'h303, 32'h303};
  logic        exp_rv [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      mor1kx_true_dpram_be_sclk #(
        .ADDR_WIDTH     (4),
        .DATA_WIDTH     (32),
        .RDW_MODE       (int'(RDW[g])),
        .OUT_REG        (int'(OREG[g])),
        .CLEAR_ON_RESET (1)
      ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .en_a_i      (en_a),
        .we_a_i      (we_a),
        .addr_a_i    (addr_a),
        .din_a_i     (din_a),
        .dout_a_o    (dout_a[g]),
        .rvalid_a_o  (rvalid_a[g]),
        .en_b_i      (en_b),
        .we_b_i      (we_b),
        .addr_b_i    (addr_b),
        .din_b_i     (din_b),
        .dout_b_o    (dout_b[g]),
        .rvalid_b_o  (rvalid_b[g]),
        .collision_o (collision[g]),
        .busy_o      (busy[g])
      );
    end
  endgenerate

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = '0;
    en_b = 1'b0; we_b = '0;
  endtask

  task automatic port_a(input logic [3:0] we, input logic [3:0] ad, input logic [31:0] d);
    en_a = 1'b1; we_a = we; addr_a = ad; din_a = d;
  endtask

  task automatic port_b(input logic [3:0] we, input logic [3:0] ad, input logic [31:0] d);
    en_b = 1'b1; we_b = we; addr_b = ad; din_b = d;
  endtask

  task automatic wait_idle();
    n = 0;
    rv_seen = 1'b0;
    while (busy[WF] !== 1'b0 && n < 200) begin
      step();
      n++;
      rv_seen = rv_seen | rvalid_a[WF];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    rst = 1'b1;
    step(); step();
    chk("rst_dout_a",   dout_a[WF],    32'h0);
    chk("rst_rvalid_a", rvalid_a[WF],  32'h0);
    chk("rst_coll",     collision[WF], 32'h0);
    chk("rst_busy",     busy[WF],      32'h1);
    chk("rst_or_doutb", dout_b[ORG],   32'h0);
    rst = 1'b0;
    wait_idle();
    chk("init_clear_len", n, 32'd16);

    // preload, then clear with a write held on port A the whole time
    port_a(4'hF, 4'd3, 32'hDEADBEEF); step();
    port_a(4'h0, 4'd3, 32'h0); step(); idle();
    chk("preload_rd", dout_a[WF], 32'hDEADBEEF);
    rst = 1'b1; step(); rst = 1'b0;
    port_a(4'hF, 4'd3, 32'h55555555);
    wait_idle();
    idle();
    chk("clr_len",       n,       32'd16);
    chk("clr_no_rvalid", rv_seen, 32'h0);
    port_a(4'h0, 4'd3, 32'h0); step(); idle();
    chk("clr_rd3",   dout_a[WF],   32'h0);
    chk("clr_rv",    rvalid_a[WF], 32'h1);
    step();
    chk("rv_pulse",  rvalid_a[WF],  32'h0);
    chk("or_rv_lat", rvalid_a[ORG], 32'h1);

    // reset again at cycle 7 of a clear
    port_b(4'hF, 4'd15, 32'hFFFFFFFF); step();
    port_b(4'hF, 4'd0,  32'h00000001); step(); idle();
    rst = 1'b1; step(); rst = 1'b0;
    repeat (6) step();
    rst = 1'b1; step(); rst = 1'b0;
    wait_idle();
    chk("mid_clr_len", n, 32'd16);
    for (int i = 0; i < 16; i++) begin
      port_a(4'h0, 4'(i), 32'h0);
      step();
      chk("mid_clr_rd", dout_a[WF], 32'h0);
    end
    idle();
    chk("mid_clr_rv", rvalid_a[WF], 32'h1);

    // byte enables
    port_a(4'hF, 4'd5, 32'h11223344); step();
    port_a(4'b0101, 4'd5, 32'hAABBCCDD); step(); idle();
    chk("be_wf", dout_a[WF], 32'h11BB33DD);
    chk("be_rf", dout_a[RF], 32'h11223344);
    port_a(4'h0, 4'd5, 32'h0); step(); idle();
    chk("be_rd",    dout_a[WF], 32'h11BB33DD);
    chk("be_rd_nc", dout_a[NC], 32'h11BB33DD);

    // read-during-write modes
    port_a(4'hF, 4'd2, 32'h1); step();
    port_a(4'hF, 4'd2, 32'h2); step(); idle();
    chk("rdw_wf",    dout_a[WF],   32'h2);
    chk("rdw_wf_rv", rvalid_a[WF], 32'h1);
    chk("rdw_rf",    dout_a[RF],   32'h1);
    chk("rdw_rf_rv", rvalid_a[RF], 32'h1);
    chk("rdw_nc",    dout_a[NC],   32'h11BB33DD);
    chk("rdw_nc_rv", rvalid_a[NC], 32'h0);

    // same-address collision
    port_a(4'b0011, 4'd9, 32'hAAAAAAAA);
    port_b(4'b1111, 4'd9, 32'hBBBBBBBB);
    step(); idle();
    chk("coll_flag",    collision[WF],  32'h1);
    chk("coll_flag_or", collision[ORG], 32'h1);
    chk("coll_wf_a",    dout_a[WF],     32'hBBBBAAAA);
    chk("coll_wf_b",    dout_b[WF],     32'hBBBBAAAA);
    chk("coll_rf_b",    dout_b[RF],     32'h0);
    step();
    chk("coll_pulse",   collision[WF],  32'h0);
    port_b(4'h0, 4'd9, 32'h0); step(); idle();
    chk("coll_rd",      dout_b[WF],     32'hBBBBAAAA);

    // output register: back-to-back reads
    port_a(4'hF, 4'd1, 32'h101); step();
    port_a(4'hF, 4'd2, 32'h202); step();
    port_a(4'hF, 4'd3, 32'h303); step();
    idle(); step(); step();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) port_a(4'h0, 4'(k + 1), 32'h0);
      else       idle();
      step();
      chk("or_rv", rvalid_a[ORG], 32'(exp_rv[k]));
      if (k > 0) chk("or_data", dout_a[ORG], exp_or[k]);
    end

    // cross-port read of a word being written
    port_a(4'hF, 4'd1, 32'h999);
    port_b(4'h0, 4'd1, 32'h0);
    step(); idle();
    chk("xport_wf", dout_b[WF], 32'h101);
    step();
    chk("xport_or",    dout_b[ORG],   32'h101);
    chk("xport_or_rv", rvalid_b[ORG], 32'h1);
    port_b(4'h0, 4'd1, 32'h0); step(); idle();
    chk("xport_new", dout_b[WF], 32'h999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
